// File: rtl/pe_pkg.sv
// Shared types for the output-stationary MAC processing element.
package pe_pkg;

  typedef enum logic [1:0] {
    ACT_PASS  = 2'b00,
    ACT_RELU  = 2'b01,
    ACT_LEAKY = 2'b10,
    ACT_RSVD  = 2'b11
  } act_mode_t;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_RUN  = 1'b1
  } acc_state_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/pe_post_proc.sv
// Activation plus width conversion of a finished dot product.
// Define PE_SAT_EN to saturate to OUT_WIDTH; otherwise the low bits are kept (wrap).
module pe_post_proc
  import pe_pkg::*;
#(
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned LEAKY_SHIFT = 3
) (
  input  logic [ACC_WIDTH-1:0] sum_in,
  input  logic [1:0]           act_mode,
  output logic [OUT_WIDTH-1:0] result_out
);

`ifdef PE_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
`endif

  logic signed [ACC_WIDTH-1:0] sum_s;
  logic signed [ACC_WIDTH-1:0] act_v;
  act_mode_t                   mode;

  always_comb begin
    sum_s = sum_in;
    mode  = act_mode_t'(act_mode);
    act_v = sum_s;
    case (mode)
      ACT_RELU:  if (sum_s[ACC_WIDTH-1]) act_v = '0;
      ACT_LEAKY: if (sum_s[ACC_WIDTH-1]) act_v = sum_s >>> LEAKY_SHIFT;
      default:   act_v = sum_s;
    endcase
`ifdef PE_SAT_EN
    if (act_v > SAT_MAX)      result_out = SAT_MAX[OUT_WIDTH-1:0];
    else if (act_v < SAT_MIN) result_out = SAT_MIN[OUT_WIDTH-1:0];
    else                      result_out = act_v[OUT_WIDTH-1:0];
`else
    result_out = act_v[OUT_WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/pe_mac_os.sv
// Output-stationary signed MAC PE: forwards operands east/south, accumulates a framed
// dot product and holds the activated result behind valid/ready. Build option: PE_SAT_EN.
module pe_mac_os
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned LEAKY_SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  valid_in,
  input  logic                  last_in,
  input  logic [1:0]            act_mode,
  input  logic                  acc_clr,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  valid_out,
  output logic                  last_out,
  output logic [OUT_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  ovf_err
);

  acc_state_t acc_state_q, acc_state_d;
  out_state_t out_state_q, out_state_d;

  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d, prod, sum;
  logic signed [DATA_WIDTH-1:0]   a_s, b_s;
  logic signed [2*DATA_WIDTH-1:0] prod_full;
  logic [OUT_WIDTH-1:0]           result_q, result_d, post_val;
  logic                           ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0]          a_q, b_q;
  logic                           valid_q, last_q;
  logic                           load;

  // acc_clr makes this beat the first one, so the running sum is ignored.
  always_comb begin
    a_s       = a_in;
    b_s       = b_in;
    prod_full = (2*DATA_WIDTH)'(a_s) * (2*DATA_WIDTH)'(b_s);
    prod      = ACC_WIDTH'(prod_full);
    sum       = ((acc_clr || acc_state_q == ACC_IDLE) ? '0 : acc_q) + prod;
    load      = valid_in & last_in;
  end

  pe_post_proc #(
    .ACC_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .LEAKY_SHIFT(LEAKY_SHIFT)
  ) u_post (
    .sum_in    (sum),
    .act_mode  (act_mode),
    .result_out(post_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_state_q <= ACC_IDLE;
      out_state_q <= OUT_EMPTY;
      acc_q       <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      acc_state_q <= acc_state_d;
      out_state_q <= out_state_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      a_q         <= a_in;
      b_q         <= b_in;
      valid_q     <= valid_in;
      last_q      <= last_in & valid_in;
    end
  end

  always_comb begin
    acc_d       = acc_q;
    acc_state_d = acc_state_q;
    if (valid_in) begin
      if (last_in) begin
        acc_d       = '0;
        acc_state_d = ACC_IDLE;
      end else begin
        acc_d       = sum;
        acc_state_d = ACC_RUN;
      end
    end else if (acc_clr) begin
      acc_d       = '0;
      acc_state_d = ACC_IDLE;
    end

    out_state_d = out_state_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    if (load) begin
      result_d    = post_val;
      out_state_d = OUT_FULL;
      if (out_state_q == OUT_FULL && !result_ready) ovf_d = 1'b1;
    end else if (out_state_q == OUT_FULL && result_ready) begin
      out_state_d = OUT_EMPTY;
    end
  end

  always_comb begin
    a_out        = a_q;
    b_out        = b_q;
    valid_out    = valid_q;
    last_out     = last_q;
    result       = result_q;
    result_valid = (out_state_q == OUT_FULL);
    ovf_err      = ovf_q;
  end

endmodule
